muldiv_sequencer: RTL and testbench
===================================

// Module: muldiv_sequencer
// PURPOSE
//   Iterative signed MULT/DIV engine plus its sequencer. It sits between the A/B operand
//   registers and the HI/LO registers, driven by the control unit.
//   It accepts a one-cycle start, runs WIDTH shift/add (mult) or shift/subtract (div) steps,
//   then pulses done together with HI/LO write enables. It reports divide-by-zero so the
//   control unit can raise the exception path.
// PARAMETERS
//   WIDTH  32  operand width; HI/LO are each WIDTH bits
//   CNT_W  6   iteration counter width; must satisfy 2**CNT_W > WIDTH
// PORTS
//   clock     in   1      system clock, rising edge
//   reset     in   1      asynchronous, active-low; clears all state
//   start     in   1      request pulse; sampled only in IDLE
//   op        in   1      0 = MULT, 1 = DIV; sampled with start
//   op_a      in   WIDTH  multiplicand / dividend (A register); sampled with start
//   op_b      in   WIDTH  multiplier / divisor (B register); sampled with start
//   busy      out  1      high whenever state != IDLE
//   done      out  1      one-cycle completion pulse
//   div_zero  out  1      one-cycle pulse, coincident with done, when DIV and op_b == 0
//   hi_out    out  WIDTH  result high word; DIV remainder
//   lo_out    out  WIDTH  result low word; DIV quotient
//   hi_write  out  1      load enable for HI register
//   lo_write  out  1      load enable for LO register
// BEHAVIOUR
//   Reset: state = IDLE; busy, done, div_zero, hi_write, lo_write, hi_out and lo_out are all 0.
//     Applies immediately, including mid-operation. Partial results are discarded.
//   States: IDLE, MULT_RUN, DIV_RUN, FINISH, DIVZ.
//   IDLE, start = 1, edge E0: latch op_a/op_b, counter <= WIDTH, then:
//     - op = 0               -> MULT_RUN
//     - op = 1, op_b != 0    -> DIV_RUN
//     - op = 1, op_b == 0    -> DIVZ
//   start while busy = 1: ignored, no queueing.
//   Operand changes after E0 have no effect.
//   MULT_RUN: signed radix-2 Booth, one step per edge, counter decrements.
//     At counter == 1, the next edge goes to FINISH.
//   DIV_RUN: restoring division on magnitudes, one quotient bit per edge.
//     At counter == 1, the next edge goes to FINISH.
//     Sign fix applies at entry to FINISH:
//       quotient is negative iff operand signs differ;
//       remainder takes the sign of the dividend.
//   FINISH: exactly one cycle, then IDLE.
//     done = hi_write = lo_write = 1.
//     hi_out/lo_out carry the result, valid from FINISH onward and held until the next
//     FINISH or reset.
//   Latency: done is high in the cycle after edge E0 + WIDTH + 1, i.e. 33 edges for WIDTH = 32.
//   DIVZ: exactly one cycle, then IDLE.
//     done = div_zero = 1; hi_write = lo_write = 0; hi_out/lo_out unchanged.
//     Latency: 1 edge after E0.
//   Arithmetic:
//     - MULT: the full 2*WIDTH-bit signed product, so no overflow is possible.
//     - DIV: most-negative / -1 wraps to LO = 0x80000000, HI = 0, with no flag.
//   The counter never wraps; it is only loaded at E0 and stops at 0.
//   A start in the same cycle as FINISH or DIVZ is ignored, because busy is still 1.
// STRUCTURE
//   Shared package muldiv_pkg:
//     - state encoding: IDLE = 0, MULT_RUN, DIV_RUN, FINISH, DIVZ
//     - OP_MULT = 1'b0, OP_DIV = 1'b1
//     - default WIDTH
//   One natural sub-module: muldiv_step, the combinational single-iteration Booth add/sub
//   and restoring-subtract step. The FSM, counter and product/remainder registers stay in
//   the top module.
// TESTING
//   1. MULT 3 x 0xFFFFFFFB (-5) -> done after 33 edges; HI = 0xFFFFFFFF, LO = 0xFFFFFFF1;
//      hi_write/lo_write high for exactly 1 cycle.
//   2. MULT 0x80000000 x 0x80000000 -> HI = 0x40000000, LO = 0x00000000.
//   3. DIV 7 / 0xFFFFFFFE (-2) -> LO = 0xFFFFFFFD (-3), HI = 1.
//      DIV 0xFFFFFFF9 (-7) / 2 -> LO = 0xFFFFFFFD, HI = 0xFFFFFFFF.
//   4. DIV 5 / 0 -> 1 edge later done = div_zero = 1, hi_write = lo_write = 0;
//      hi_out/lo_out keep prior values; busy is low on the following cycle.
//   5. DIV 0x80000000 / 0xFFFFFFFF -> LO = 0x80000000, HI = 0, div_zero = 0.
//   6. Busy and reset handling:
//      - start MULT, then pulse start again at cycle 5 -> second request ignored;
//        a single done at 33 edges.
//      - reset asserted at cycle 10 of a MULT -> outputs 0 and IDLE at once;
//        a new MULT 2 x 2 afterwards gives LO = 4.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative signed MULT/DIV sequencer:
// state encoding, operation codes and default widths.
package muldiv_pkg;

  localparam int unsigned DEFAULT_WIDTH = 32;
  localparam int unsigned DEFAULT_CNT_W = 6;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    MULT_RUN = 3'd1,
    DIV_RUN  = 3'd2,
    FINISH   = 3'd3,
    DIVZ     = 3'd4
  } state_t;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the engine: radix-2 Booth add/sub + arithmetic shift for MULT,
// or one restoring shift/subtract quotient bit for DIV (on magnitudes).
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             op,
  input  logic [WIDTH:0]   acc_hi,
  input  logic [WIDTH-1:0] acc_lo,
  input  logic             q_m1,
  input  logic [WIDTH-1:0] opnd,
  output logic [WIDTH:0]   hi_next_c,
  output logic [WIDTH-1:0] lo_next_c,
  output logic             q_m1_next_c
);

  logic [WIDTH:0] m_ext;
  logic [WIDTH:0] booth_sum;
  logic [WIDTH:0] div_shift;
  logic [WIDTH:0] div_diff;

  always_comb begin
    hi_next_c   = acc_hi;
    lo_next_c   = acc_lo;
    q_m1_next_c = 1'b0;

    // The extra accumulator bit keeps A +/- M from overflowing at the extremes.
    m_ext     = {opnd[WIDTH-1], opnd};
    booth_sum = acc_hi;
    if ({acc_lo[0], q_m1} == 2'b01) begin
      booth_sum = acc_hi + m_ext;
    end else if ({acc_lo[0], q_m1} == 2'b10) begin
      booth_sum = acc_hi - m_ext;
    end

    div_shift = {acc_hi[WIDTH-1:0], acc_lo[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd};

    if (op == OP_MULT) begin
      hi_next_c   = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
      lo_next_c   = {booth_sum[0], acc_lo[WIDTH-1:1]};
      q_m1_next_c = acc_lo[0];
    end else if (!div_diff[WIDTH]) begin
      hi_next_c = div_diff;
      lo_next_c = {acc_lo[WIDTH-2:0], 1'b1};
    end else begin
      hi_next_c = div_shift;
      lo_next_c = {acc_lo[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative signed MULT/DIV engine with its sequencer: takes a start pulse, runs WIDTH
// steps and pulses done with HI/LO write enables; flags divide-by-zero in one cycle.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned CNT_W = DEFAULT_CNT_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic             hi_write,
  output logic             lo_write
);

  state_t           state, state_d;
  logic             busy_d, done_d, div_zero_d, write_d;

  logic [CNT_W-1:0] cnt;
  logic [WIDTH:0]   acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic [WIDTH-1:0] opnd;
  logic             q_m1;
  logic             neg_q;
  logic             neg_r;

  logic             step_op_c;
  logic [WIDTH:0]   hi_next_c;
  logic [WIDTH-1:0] lo_next_c;
  logic             q_m1_next_c;
  logic             run_last_c;
  logic [WIDTH-1:0] a_mag_c, b_mag_c;
  logic [WIDTH-1:0] hi_res_c, lo_res_c;

  // Next-state and registered-output decode
  always_comb begin
    state_d    = state;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    div_zero_d = 1'b0;
    write_d    = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          if (op == OP_MULT)     state_d = MULT_RUN;
          else if (op_b == '0)   state_d = DIVZ;
          else                   state_d = DIV_RUN;
        end
      end
      MULT_RUN, DIV_RUN: begin
        if (cnt == CNT_W'(1)) state_d = FINISH;
      end
      FINISH, DIVZ: state_d = IDLE;
      default:      state_d = IDLE;
    endcase

    busy_d     = (state_d != IDLE);
    done_d     = (state_d == FINISH) || (state_d == DIVZ);
    div_zero_d = (state_d == DIVZ);
    write_d    = (state_d == FINISH);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi_write <= 1'b0;
      lo_write <= 1'b0;
    end else begin
      state    <= state_d;
      busy     <= busy_d;
      done     <= done_d;
      div_zero <= div_zero_d;
      hi_write <= write_d;
      lo_write <= write_d;
    end
  end

  assign step_op_c  = (state == DIV_RUN) ? OP_DIV : OP_MULT;
  assign run_last_c = ((state == MULT_RUN) || (state == DIV_RUN)) && (cnt == CNT_W'(1));
  assign a_mag_c    = op_a[WIDTH-1] ? WIDTH'(-op_a) : op_a;
  assign b_mag_c    = op_b[WIDTH-1] ? WIDTH'(-op_b) : op_b;

  muldiv_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .op         (step_op_c),
    .acc_hi     (acc_hi),
    .acc_lo     (acc_lo),
    .q_m1       (q_m1),
    .opnd       (opnd),
    .hi_next_c  (hi_next_c),
    .lo_next_c  (lo_next_c),
    .q_m1_next_c(q_m1_next_c)
  );

  // Final result: MULT takes the product directly, DIV applies the sign fix-up
  always_comb begin
    hi_res_c = hi_next_c[WIDTH-1:0];
    lo_res_c = lo_next_c;
    if (state == DIV_RUN) begin
      lo_res_c = neg_q ? WIDTH'(-lo_next_c) : lo_next_c;
      hi_res_c = neg_r ? WIDTH'(-hi_next_c[WIDTH-1:0]) : hi_next_c[WIDTH-1:0];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt    <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      opnd   <= '0;
      q_m1   <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      hi_out <= '0;
      lo_out <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            cnt    <= CNT_W'(WIDTH);
            acc_hi <= '0;
            q_m1   <= 1'b0;
            neg_q  <= op_a[WIDTH-1] ^ op_b[WIDTH-1];
            neg_r  <= op_a[WIDTH-1];
            if (op == OP_MULT) begin
              acc_lo <= op_b;
              opnd   <= op_a;
            end else begin
              acc_lo <= a_mag_c;
              opnd   <= b_mag_c;
            end
          end
        end
        MULT_RUN, DIV_RUN: begin
          acc_hi <= hi_next_c;
          acc_lo <= lo_next_c;
          q_m1   <= q_m1_next_c;
          if (cnt != '0) cnt <= cnt - CNT_W'(1);
          if (run_last_c) begin
            hi_out <= hi_res_c;
            lo_out <= lo_res_c;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Randomized self-checking bench for muldiv_sequencer against a plain-arithmetic
// reference (64-bit signed multiply, truncating signed divide/modulo).
module tb_muldiv_sequencer;

  logic        clock;
  logic        reset;
  logic        start;
  logic        op;
  logic [31:0] op_a, op_b;
  logic        busy, done, div_zero, hi_write, lo_write;
  logic [31:0] hi_out, lo_out;

  int unsigned total = 0;
  int unsigned bad   = 0;

  muldiv_sequencer #(.WIDTH(32), .CNT_W(6)) dut (
    .clock   (clock),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .op_a    (op_a),
    .op_b    (op_b),
    .busy    (busy),
    .done    (done),
    .div_zero(div_zero),
    .hi_out  (hi_out),
    .lo_out  (lo_out),
    .hi_write(hi_write),
    .lo_write(lo_write)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic [63:0] ref_mult(input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    return 64'(sa * sb);
  endfunction

  function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    q  = 32'(sa / sb);
    r  = 32'(sa % sb);
  endfunction

  function automatic logic [31:0] pick_operand();
    logic [31:0] v;
    case ($urandom_range(0, 7))
      0:       v = 32'h8000_0000;
      1:       v = 32'hFFFF_FFFF;
      2:       v = 32'h7FFF_FFFF;
      3:       v = 32'h0000_0001;
      default: v = $urandom;
    endcase
    return v;
  endfunction

  // Issues one request, scrambles operands after the accept edge, and reports
  // the edge count to done plus the outputs in and after the done cycle.
  task automatic run_op(input logic o, input logic [31:0] a, input logic [31:0] b,
                        output int edges, output logic dz, output logic hw, output logic lw,
                        output logic [31:0] hi, output logic [31:0] lo,
                        output logic busy_after, output logic pulse_after);
    @(negedge clock);
    start = 1'b1; op = o; op_a = a; op_b = b;
    @(negedge clock);
    start = 1'b0; op = 1'($urandom); op_a = $urandom; op_b = $urandom;
    edges = 1;
    while (!done && edges < 100) begin
      @(negedge clock);
      edges++;
    end
    dz = div_zero; hw = hi_write; lw = lo_write; hi = hi_out; lo = lo_out;
    @(negedge clock);
    busy_after  = busy;
    pulse_after = done | hi_write | lo_write | div_zero;
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; op = 1'b0; op_a = '0; op_b = '0;
    repeat (3) @(negedge clock);
    total++;
    if ({busy, done, div_zero, hi_write, lo_write} !== 5'b0) begin
      bad++; $display("FAIL reset_flags: got %b expected 00000", {busy, done, div_zero, hi_write, lo_write});
    end
    total++;
    if (hi_out !== 32'h0 || lo_out !== 32'h0) begin
      bad++; $display("FAIL reset_data: got hi=%h lo=%h expected 0/0", hi_out, lo_out);
    end
    reset = 1'b1;
  endtask

  task automatic test_mult();
    logic [31:0] av [4] = '{32'h0000_0003, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0000};
    logic [31:0] bv [4] = '{32'hFFFF_FFFB, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF};
    logic [31:0] a, b, hi, lo;
    logic [63:0] p;
    logic dz, hw, lw, ba, pa;
    int edges;
    for (int i = 0; i < 16; i++) begin
      if (i < 4) begin a = av[i]; b = bv[i]; end
      else begin a = pick_operand(); b = pick_operand(); end
      p = ref_mult(a, b);
      run_op(1'b0, a, b, edges, dz, hw, lw, hi, lo, ba, pa);
      total++;
      if (edges !== 33) begin bad++; $display("FAIL mult_latency a=%h b=%h: got %0d expected 33", a, b, edges); end
      total++;
      if ({hw, lw, dz} !== 3'b110) begin bad++; $display("FAIL mult_flags: got hw/lw/dz=%b expected 110", {hw, lw, dz}); end
      total++;
      if ({hi, lo} !== p) begin bad++; $display("FAIL mult_result a=%h b=%h: got %h_%h expected %h", a, b, hi, lo, p); end
      total++;
      if (ba !== 1'b0 || pa !== 1'b0) begin bad++; $display("FAIL mult_one_cycle: got busy=%b pulse=%b expected 0/0", ba, pa); end
    end
  endtask

  task automatic test_div();
    logic [31:0] av [3] = '{32'h0000_0007, 32'hFFFF_FFF9, 32'h8000_0000};
    logic [31:0] bv [3] = '{32'hFFFF_FFFE, 32'h0000_0002, 32'hFFFF_FFFF};
    logic [31:0] a, b, hi, lo, q, r;
    logic dz, hw, lw, ba, pa;
    int edges;
    for (int i = 0; i < 15; i++) begin
      if (i < 3) begin a = av[i]; b = bv[i]; end
      else begin
        a = pick_operand(); b = pick_operand();
        if ($urandom_range(0, 2) == 0) b = 32'($urandom_range(1, 50));
        if (b == 32'h0) b = 32'h3;
      end
      ref_div(a, b, q, r);
      run_op(1'b1, a, b, edges, dz, hw, lw, hi, lo, ba, pa);
      total++;
      if (edges !== 33) begin bad++; $display("FAIL div_latency a=%h b=%h: got %0d expected 33", a, b, edges); end
      total++;
      if ({hw, lw, dz} !== 3'b110) begin bad++; $display("FAIL div_flags: got hw/lw/dz=%b expected 110", {hw, lw, dz}); end
      total++;
      if (lo !== q || hi !== r) begin
        bad++; $display("FAIL div_result a=%h b=%h: got q=%h r=%h expected q=%h r=%h", a, b, lo, hi, q, r);
      end
      total++;
      if (ba !== 1'b0 || pa !== 1'b0) begin bad++; $display("FAIL div_one_cycle: got busy=%b pulse=%b expected 0/0", ba, pa); end
    end
  endtask

  task automatic test_div_zero();
    logic [31:0] hi, lo;
    logic dz, hw, lw, ba, pa;
    int edges;
    run_op(1'b0, 32'd3, 32'd5, edges, dz, hw, lw, hi, lo, ba, pa);
    total++;
    if (lo !== 32'd15 || hi !== 32'd0) begin bad++; $display("FAIL divz_setup: got hi=%h lo=%h expected 0/f", hi, lo); end
    run_op(1'b1, 32'd5, 32'd0, edges, dz, hw, lw, hi, lo, ba, pa);
    total++;
    if (edges !== 1) begin bad++; $display("FAIL divz_latency: got %0d expected 1", edges); end
    total++;
    if ({dz, hw, lw} !== 3'b100) begin bad++; $display("FAIL divz_flags: got dz/hw/lw=%b expected 100", {dz, hw, lw}); end
    total++;
    if (hi !== 32'd0 || lo !== 32'd15) begin bad++; $display("FAIL divz_hold: got hi=%h lo=%h expected 0/f", hi, lo); end
    total++;
    if (ba !== 1'b0 || pa !== 1'b0) begin bad++; $display("FAIL divz_after: got busy=%b pulse=%b expected 0/0", ba, pa); end
  endtask

  task automatic test_busy_ignore();
    logic [31:0] a, b, hi, lo;
    logic [63:0] p;
    int first_done, n_done;
    logic busy_late;
    a = $urandom; b = $urandom;
    p = ref_mult(a, b);
    first_done = 0; n_done = 0; busy_late = 1'b0; hi = '0; lo = '0;
    @(negedge clock);
    start = 1'b1; op = 1'b0; op_a = a; op_b = b;
    @(negedge clock);
    start = 1'b0;
    for (int e = 1; e <= 45; e++) begin
      if (first_done != 0 && e > first_done && busy) busy_late = 1'b1;
      if (done) begin
        n_done++;
        if (first_done == 0) begin
          first_done = e; hi = hi_out; lo = lo_out;
          start = 1'b1; op = 1'b0; op_a = $urandom; op_b = $urandom;
        end
      end
      if (e == 5) begin start = 1'b1; op = 1'b1; op_a = $urandom; op_b = 32'h0; end
      else if (e == 6 || (first_done != 0 && e == first_done + 1)) start = 1'b0;
      @(negedge clock);
    end
    start = 1'b0;
    total++;
    if (n_done !== 1) begin bad++; $display("FAIL busy_done_count: got %0d expected 1", n_done); end
    total++;
    if (first_done !== 33) begin bad++; $display("FAIL busy_latency: got %0d expected 33", first_done); end
    total++;
    if ({hi, lo} !== p) begin bad++; $display("FAIL busy_result: got %h_%h expected %h", hi, lo, p); end
    total++;
    if (busy_late !== 1'b0) begin bad++; $display("FAIL finish_start_ignored: got busy=%b expected 0", busy_late); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] hi, lo;
    logic dz, hw, lw, ba, pa;
    int edges;
    @(negedge clock);
    start = 1'b1; op = 1'b0; op_a = $urandom | 32'h1; op_b = $urandom | 32'h1;
    @(negedge clock);
    start = 1'b0;
    repeat (9) @(negedge clock);
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL mid_busy: got %b expected 1", busy); end
    #2 reset = 1'b0;
    #1;
    total++;
    if ({busy, done, div_zero, hi_write, lo_write} !== 5'b0) begin
      bad++; $display("FAIL mid_reset_flags: got %b expected 00000", {busy, done, div_zero, hi_write, lo_write});
    end
    total++;
    if (hi_out !== 32'h0 || lo_out !== 32'h0) begin
      bad++; $display("FAIL mid_reset_data: got hi=%h lo=%h expected 0/0", hi_out, lo_out);
    end
    @(negedge clock);
    reset = 1'b1;
    run_op(1'b0, 32'd2, 32'd2, edges, dz, hw, lw, hi, lo, ba, pa);
    total++;
    if (edges !== 33 || lo !== 32'd4 || hi !== 32'd0) begin
      bad++; $display("FAIL post_reset_mult: got edges=%0d hi=%h lo=%h expected 33/0/4", edges, hi, lo);
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_div_zero();
    test_busy_ignore();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
